// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sampling of data,
// parity and stop bits, LSB-first assembly and a valid/ready host interface.
//
// Host handshake: rx_data and parity_err are meaningful only while rx_valid=1;
// a byte is transferred on every rising clk edge where rx_valid=1 and
// rx_ready=1. rx_valid then falls on the next cycle unless a new byte is
// delivered on that same edge, in which case it stays high with the new data.
`timescale 1ns/1ps
module uart_rx_ctrl #(
   parameter int OVS        = 16,
   parameter int CNT_LEN    = 5,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rxd,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy,
   output logic [2:0]           dbg_state   // 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam logic [CNT_LEN-1:0] OS_HALF  = CNT_LEN'(OVS / 2 - 1);
   localparam logic [CNT_LEN-1:0] OS_LAST  = CNT_LEN'(OVS - 1);
   localparam logic [3:0]         BIT_LAST = 4'(DATA_BITS - 1);

   state_t                 r_state;
   logic [CNT_LEN-1:0]     r_os_cnt;
   logic [3:0]             r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_par_bit;
   logic                   r_rx_meta;
   logic                   r_rxs;
   logic                   r_rxs_d;
   logic                   r_edge_pend;
   logic [DATA_BITS-1:0]   r_rx_data;
   logic                   r_rx_valid;
   logic                   r_parity_err;
   logic                   r_frame_err;
   logic                   r_overrun;

   logic                   w_fall;
   logic                   w_par_err;

   assign w_fall    = r_rxs_d & ~r_rxs;
   assign w_par_err = (PARITY_EN != 0) ? ((^{r_shift, r_par_bit}) ^ (PARITY_ODD != 0)) : 1'b0;

   // Two-flop synchroniser for the asynchronous line plus one delay stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
         r_rxs_d   <= 1'b1;
      end else begin
         r_rx_meta <= rxd;
         r_rxs     <= r_rx_meta;
         r_rxs_d   <= r_rxs;
      end
   end

   // Receive FSM with its counters, shift register and registered host-side outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_os_cnt     <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_bit    <= 1'b0;
         r_edge_pend  <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_edge_pend <= 1'b0;
         // Acceptance; a delivery in the STOP branch below overrides this
         if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               // r_edge_pend remembers an edge that arrived while STOP was completing
               if (w_fall || r_edge_pend) begin
                  r_state  <= S_START;
                  r_os_cnt <= '0;
               end
            end
            S_START: begin
               if (baud_tick) begin
                  if (r_os_cnt == OS_HALF) begin
                     r_os_cnt <= '0;
                     if (!r_rxs) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  if (r_os_cnt == OS_LAST) begin
                     r_os_cnt  <= '0;
                     r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == BIT_LAST) begin
                        r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                     end
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (baud_tick) begin
                  if (r_os_cnt == OS_LAST) begin
                     r_os_cnt  <= '0;
                     r_par_bit <= r_rxs;
                     r_state   <= S_STOP;
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
            end
            S_STOP: begin
               r_edge_pend <= w_fall;
               if (baud_tick) begin
                  if (r_os_cnt == OS_LAST) begin
                     r_os_cnt <= '0;
                     r_state  <= S_IDLE;
                     if (r_rxs) begin
                        if (!r_rx_valid || rx_ready) begin
                           r_rx_data    <= r_shift;
                           r_parity_err <= w_par_err;
                           r_rx_valid   <= 1'b1;
                        end else begin
                           r_overrun <= 1'b1;
                        end
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign busy       = (r_state != S_IDLE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: one instance without parity, one with even parity.
// Serial frames are driven at 16 ticks per bit with a tick every 4 clocks.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

   localparam int BIT_CLKS = 64;

   logic clk = 1'b0;
   logic rst, baud_tick, rxd, rxd_p, rx_ready, rx_ready_p;

   logic [7:0] rx_data, rx_data_p;
   logic       rx_valid, parity_err, frame_err, overrun, busy;
   logic       rx_valid_p, parity_err_p, frame_err_p, overrun_p, busy_p;
   logic [2:0] dbg_state, dbg_state_p;

   int checks   = 0;
   int failures = 0;

   logic [8:0] exp_q[$];
   logic [8:0] exp_p_q[$];

   int n_deliv = 0, n_valid_cyc = 0, n_ferr = 0, n_ovr = 0;
   int n_deliv_p = 0, n_ferr_p = 0, n_ovr_p = 0;

   uart_rx_ctrl #(.OVS(16), .CNT_LEN(5), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
      .frame_err(frame_err), .overrun(overrun), .busy(busy), .dbg_state(dbg_state)
   );

   uart_rx_ctrl #(.OVS(16), .CNT_LEN(5), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd_p), .rx_ready(rx_ready_p),
      .rx_data(rx_data_p), .rx_valid(rx_valid_p), .parity_err(parity_err_p),
      .frame_err(frame_err_p), .overrun(overrun_p), .busy(busy_p), .dbg_state(dbg_state_p)
   );

   // ---------------- clock / reset / tick ----------------
   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   // ---------------- scoreboard monitors ----------------
   logic       prev_v = 1'b0, prev_acc = 1'b0, prev_stop_tick = 1'b0;
   logic [8:0] ev;

   always @(negedge clk) begin
      #2;
      if (rx_valid === 1'b1) n_valid_cyc++;
      if (frame_err === 1'b1) n_ferr++;
      if (overrun === 1'b1) n_ovr++;
      if (rx_valid === 1'b1 && (!prev_v || prev_acc)) begin
         n_deliv++;
         checks++;
         if (!prev_stop_tick) begin
            failures++;
            $display("FAIL deliv_timing: delivery not one cycle after a stop tick");
         end
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_delivery got=%h expected none", rx_data);
         end else begin
            ev = exp_q.pop_front();
            if ({parity_err, rx_data} !== ev) begin
               failures++;
               $display("FAIL sb_data got perr=%b data=%h expected perr=%b data=%h",
                        parity_err, rx_data, ev[8], ev[7:0]);
            end
         end
      end
      prev_v         = (rx_valid === 1'b1);
      prev_acc       = (rx_valid === 1'b1) && rx_ready;
      prev_stop_tick = (dbg_state == 3'd4) && baud_tick;
   end

   logic       prev_v_p = 1'b0, prev_acc_p = 1'b0, prev_stop_tick_p = 1'b0;
   logic [8:0] ev_p;

   always @(negedge clk) begin
      #2;
      if (frame_err_p === 1'b1) n_ferr_p++;
      if (overrun_p === 1'b1) n_ovr_p++;
      if (rx_valid_p === 1'b1 && (!prev_v_p || prev_acc_p)) begin
         n_deliv_p++;
         checks++;
         if (!prev_stop_tick_p) begin
            failures++;
            $display("FAIL deliv_timing_p: delivery not one cycle after a stop tick");
         end
         checks++;
         if (exp_p_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_delivery_p got=%h expected none", rx_data_p);
         end else begin
            ev_p = exp_p_q.pop_front();
            if ({parity_err_p, rx_data_p} !== ev_p) begin
               failures++;
               $display("FAIL sb_data_p got perr=%b data=%h expected perr=%b data=%h",
                        parity_err_p, rx_data_p, ev_p[8], ev_p[7:0]);
            end
         end
      end
      prev_v_p         = (rx_valid_p === 1'b1);
      prev_acc_p       = (rx_valid_p === 1'b1) && rx_ready_p;
      prev_stop_tick_p = (dbg_state_p == 3'd4) && baud_tick;
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic v, input logic to_p);
      if (to_p) rxd_p = v;
      else      rxd   = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                             input logic stop, input logic to_p);
      drive_bit(1'b0, to_p);
      for (int i = 0; i < 8; i++) drive_bit(d[i], to_p);
      if (has_par) drive_bit(pbit, to_p);
      drive_bit(stop, to_p);
      if (!stop) drive_bit(1'b1, to_p);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; rxd = 1'b1; rxd_p = 1'b1; rx_ready = 1'b1; rx_ready_p = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rx_valid, parity_err, frame_err, overrun, busy} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b expected=00000",
                  {rx_valid, parity_err, frame_err, overrun, busy});
      end
      checks++;
      if (rx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_data got=%h expected=00", rx_data);
      end
      checks++;
      if ({rx_valid_p, parity_err_p, busy_p, rx_data_p} !== 11'b0) begin
         failures++;
         $display("FAIL reset_p got=%b expected=0", {rx_valid_p, parity_err_p, busy_p, rx_data_p});
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dbg_state !== 3'd0) begin
         failures++;
         $display("FAIL reset_idle busy=%b state=%0d expected busy=0 state=0", busy, dbg_state);
      end
   endtask

   task automatic test_basic();
      int d0, v0;
      d0 = n_deliv; v0 = n_valid_cyc;
      exp_q.push_back({1'b0, 8'hA5});
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checks++;
      if (n_deliv - d0 != 1) begin
         failures++;
         $display("FAIL basic_count got=%0d expected=1", n_deliv - d0);
      end
      checks++;
      if (n_valid_cyc - v0 != 1) begin
         failures++;
         $display("FAIL basic_valid_width got=%0d expected=1", n_valid_cyc - v0);
      end
      checks++;
      if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
         failures++;
         $display("FAIL basic_after_accept valid=%b data=%h expected valid=0 data=a5", rx_valid, rx_data);
      end
   endtask

   task automatic test_glitch();
      int d0, f0, o0;
      d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
      rxd = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL glitch_start busy=%b expected=1", busy);
      end
      repeat (8) @(negedge clk);
      rxd = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL glitch_idle busy=%b expected=0", busy);
      end
      checks++;
      if (n_deliv != d0 || n_ferr != f0 || n_ovr != o0) begin
         failures++;
         $display("FAIL glitch_flags deliv=%0d ferr=%0d ovr=%0d expected 0 0 0",
                  n_deliv - d0, n_ferr - f0, n_ovr - o0);
      end
   endtask

   task automatic test_frame_err();
      int d0, f0;
      d0 = n_deliv; f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (n_ferr - f0 != 1) begin
         failures++;
         $display("FAIL frame_err_pulse got=%0d cycles expected=1", n_ferr - f0);
      end
      checks++;
      if (n_deliv != d0 || rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL frame_err_discard deliv=%0d valid=%b expected 0 0", n_deliv - d0, rx_valid);
      end
      exp_q.push_back({1'b0, 8'h55});
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (n_deliv - d0 != 1 || rx_data !== 8'h55) begin
         failures++;
         $display("FAIL frame_err_recover deliv=%0d data=%h expected 1 55", n_deliv - d0, rx_data);
      end
   endtask

   task automatic test_overrun();
      int o0;
      o0 = n_ovr;
      rx_ready = 1'b0;
      exp_q.push_back({1'b0, 8'h11});
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
         failures++;
         $display("FAIL hold_first valid=%b data=%h expected 1 11", rx_valid, rx_data);
      end
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (n_ovr - o0 != 1) begin
         failures++;
         $display("FAIL overrun_pulse got=%0d cycles expected=1", n_ovr - o0);
      end
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
         failures++;
         $display("FAIL overrun_keep valid=%b data=%h expected 1 11", rx_valid, rx_data);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin
         failures++;
         $display("FAIL overrun_accept valid=%b data=%h expected 0 11", rx_valid, rx_data);
      end
      rx_ready = 1'b1;
   endtask

   task automatic test_parity();
      int d0;
      d0 = n_deliv_p;
      exp_p_q.push_back({1'b1, 8'h07});
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_p_q.push_back({1'b0, 8'h07});
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
      exp_p_q.push_back({1'b0, 8'hA5});
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
      exp_p_q.push_back({1'b1, 8'hA5});
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (n_deliv_p - d0 != 4 || n_ferr_p != 0 || n_ovr_p != 0) begin
         failures++;
         $display("FAIL parity_count deliv=%0d ferr=%0d ovr=%0d expected 4 0 0",
                  n_deliv_p - d0, n_ferr_p, n_ovr_p);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      logic [7:0] b;
      d0 = n_deliv;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back({1'b0, b});
         send_frame(b, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (n_deliv - d0 != 4) begin
         failures++;
         $display("FAIL b2b_count got=%0d expected=4", n_deliv - d0);
      end
   endtask

   task automatic test_reset_mid();
      int d0, f0, o0, ticks, guard;
      logic [7:0] d;
      logic done;
      d = 8'h5A;
      d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
      // abort inside data bit 3
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d[i], 1'b0);
      rxd = d[3];
      repeat (BIT_CLKS / 2) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_busy busy=%b expected=1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rxd = 1'b1;
      checks++;
      if ({busy, rx_valid, parity_err, frame_err, overrun} !== 5'b0) begin
         failures++;
         $display("FAIL mid_reset got=%b expected=00000", {busy, rx_valid, parity_err, frame_err, overrun});
      end
      repeat (BIT_CLKS) @(negedge clk);
      exp_q.push_back({1'b0, 8'h5A});
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (n_deliv - d0 != 1 || rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL mid_recover deliv=%0d data=%h expected 1 5a", n_deliv - d0, rx_data);
      end
      // reset landing on the stop-sample tick
      d0 = n_deliv;
      ticks = 0; guard = 0; done = 1'b0;
      fork
         send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
         begin
            while (!done && guard < 2000) begin
               @(negedge clk);
               #1;
               guard++;
               if (dbg_state == 3'd4 && baud_tick) ticks++;
               if (ticks == 16) begin
                  rst = 1'b1;
                  @(negedge clk);
                  rst = 1'b0;
                  done = 1'b1;
                  checks++;
                  if (busy !== 1'b0 || rx_valid !== 1'b0) begin
                     failures++;
                     $display("FAIL stop_reset busy=%b valid=%b expected 0 0", busy, rx_valid);
                  end
               end
            end
            if (!done) begin
               checks++;
               failures++;
               $display("FAIL stop_wait_timeout state=%0d expected STOP reached", dbg_state);
            end
         end
      join
      repeat (8) @(negedge clk);
      checks++;
      if (n_deliv != d0 || n_ferr != f0 || n_ovr != o0) begin
         failures++;
         $display("FAIL stop_reset_drop deliv=%0d ferr=%0d ovr=%0d expected 0 0 0",
                  n_deliv - d0, n_ferr - f0, n_ovr - o0);
      end
      exp_q.push_back({1'b0, 8'h5A});
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (n_deliv - d0 != 1 || rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL stop_reset_recover deliv=%0d data=%h expected 1 5a", n_deliv - d0, rx_data);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; rxd = 1'b1; rxd_p = 1'b1; rx_ready = 1'b1; rx_ready_p = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_parity();
      test_back_to_back();
      test_reset_mid();
      repeat (10) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || exp_p_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain pending=%0d/%0d expected 0/0", exp_q.size(), exp_p_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
